// File: rtl/sargantana_icache_access_sched_if.sv
// Request/grant bundle between the I-cache access scheduler, its requesters
// (core, refill engine, upper level) and the replace unit control inputs.
interface sargantana_icache_access_sched_if #(
    parameter int unsigned IDX_W = 6
);
    logic             flush_req_i;
    logic             flush_busy_o;
    logic             flush_ack_o;
    logic             inval_req_i;
    logic [IDX_W-1:0] inval_idx_i;
    logic             inval_ack_o;
    logic             refill_req_i;
    logic [IDX_W-1:0] refill_idx_i;
    logic             refill_gnt_o;
    logic             rd_req_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_gnt_o;
    logic             flush_ena_o;
    logic             inval_o;
    logic             cache_rd_ena_o;
    logic             cache_wr_ena_o;
    logic [IDX_W-1:0] cline_index_o;

    modport master (
        output flush_req_i, inval_req_i, inval_idx_i, refill_req_i, refill_idx_i,
               rd_req_i, rd_idx_i,
        input  flush_busy_o, flush_ack_o, inval_ack_o, refill_gnt_o, rd_gnt_o,
               flush_ena_o, inval_o, cache_rd_ena_o, cache_wr_ena_o, cline_index_o
    );

    modport slave (
        input  flush_req_i, inval_req_i, inval_idx_i, refill_req_i, refill_idx_i,
               rd_req_i, rd_idx_i,
        output flush_busy_o, flush_ack_o, inval_ack_o, refill_gnt_o, rd_gnt_o,
               flush_ena_o, inval_o, cache_rd_ena_o, cache_wr_ena_o, cline_index_o
    );
endinterface

// File: rtl/sargantana_icache_access_sched.sv
// I-cache access scheduler: arbitrates flush walk, refill, invalidation and lookup.
// Optional macro ICACHE_FLUSH_ON_RESET_EN starts a full flush walk out of reset.
module sargantana_icache_access_sched #(
    parameter int unsigned ICACHE_N_WAY     = 4,
    parameter int unsigned ICACHE_IDX_WIDTH = 6
) (
    input logic                             clk_i,
    input logic                             rst_i,
    sargantana_icache_access_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH_START,
        FLUSH_WALK,
        FLUSH_DONE
    } state_e;

`ifdef ICACHE_FLUSH_ON_RESET_EN
    localparam state_e RESET_STATE = FLUSH_START;
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    localparam logic [ICACHE_IDX_WIDTH-1:0] LAST_IDX = {ICACHE_IDX_WIDTH{1'b1}};

    if (ICACHE_N_WAY == 0 || ICACHE_IDX_WIDTH == 0) begin : g_bad_cfg
        $error("sargantana_icache_access_sched: ways and index width must be non-zero");
    end

    state_e                      state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                        reflush_pend_q, reflush_pend_d;
    logic                        inval_vld_q, inval_vld_d;
    logic [ICACHE_IDX_WIDTH-1:0] inval_idx_q, inval_idx_d;

    logic                        drain;
    logic                        flush_busy, flush_ack, inval_ack, refill_gnt, rd_gnt;
    logic                        flush_ena, inval, rd_ena, wr_ena;
    logic [ICACHE_IDX_WIDTH-1:0] cline_index;

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        reflush_pend_d = reflush_pend_q;
        inval_vld_d    = inval_vld_q;
        inval_idx_d    = inval_idx_q;
        drain          = 1'b0;
        flush_busy     = 1'b0;
        flush_ack      = 1'b0;
        inval_ack      = 1'b0;
        refill_gnt     = 1'b0;
        rd_gnt         = 1'b0;
        flush_ena      = 1'b0;
        inval          = 1'b0;
        rd_ena         = 1'b0;
        wr_ena         = 1'b0;
        cline_index    = '0;

        case (state_q)
            IDLE: begin
                if (bus.flush_req_i) begin
                    state_d = FLUSH_START;
                end else if (bus.refill_req_i) begin
                    wr_ena      = 1'b1;
                    refill_gnt  = 1'b1;
                    cline_index = bus.refill_idx_i;
                end else if (inval_vld_q) begin
                    inval       = 1'b1;
                    drain       = 1'b1;
                    cline_index = inval_idx_q;
                end else if (bus.rd_req_i) begin
                    rd_ena      = 1'b1;
                    rd_gnt      = 1'b1;
                    cline_index = bus.rd_idx_i;
                end
            end
            FLUSH_START: begin
                flush_busy  = 1'b1;
                flush_ena   = 1'b1;
                drain       = 1'b1;
                flush_cnt_d = '0;
                state_d     = FLUSH_WALK;
                if (bus.flush_req_i) reflush_pend_d = 1'b1;
            end
            FLUSH_WALK: begin
                flush_busy  = 1'b1;
                inval       = 1'b1;
                drain       = 1'b1;
                cline_index = flush_cnt_q;
                if (bus.flush_req_i) reflush_pend_d = 1'b1;
                // The counter returns to 0 only on the hand-off to FLUSH_DONE.
                if (flush_cnt_q == LAST_IDX) begin
                    flush_cnt_d = '0;
                    state_d     = FLUSH_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            FLUSH_DONE: begin
                flush_busy = 1'b1;
                flush_ack  = 1'b1;
                drain      = 1'b1;
                // A request arriving in this last cycle merges into the pending re-flush.
                if (reflush_pend_q || bus.flush_req_i) begin
                    reflush_pend_d = 1'b0;
                    state_d        = FLUSH_START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // During a flush the buffer keeps acking but every entry is discarded.
        inval_ack = bus.inval_req_i & (~inval_vld_q | drain);
        if (state_q != IDLE) begin
            inval_vld_d = 1'b0;
        end else if (inval_ack) begin
            inval_vld_d = 1'b1;
            inval_idx_d = bus.inval_idx_i;
        end else if (drain) begin
            inval_vld_d = 1'b0;
        end

        if (rst_i) begin
            flush_busy  = 1'b0;
            flush_ack   = 1'b0;
            inval_ack   = 1'b0;
            refill_gnt  = 1'b0;
            rd_gnt      = 1'b0;
            flush_ena   = 1'b0;
            inval       = 1'b0;
            rd_ena      = 1'b0;
            wr_ena      = 1'b0;
            cline_index = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RESET_STATE;
            flush_cnt_q    <= '0;
            reflush_pend_q <= 1'b0;
            inval_vld_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            reflush_pend_q <= reflush_pend_d;
            inval_vld_q    <= inval_vld_d;
        end
    end

    // Index payload is qualified by inval_vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        inval_idx_q <= inval_idx_d;
    end

    assign bus.flush_busy_o   = flush_busy;
    assign bus.flush_ack_o    = flush_ack;
    assign bus.inval_ack_o    = inval_ack;
    assign bus.refill_gnt_o   = refill_gnt;
    assign bus.rd_gnt_o       = rd_gnt;
    assign bus.flush_ena_o    = flush_ena;
    assign bus.inval_o        = inval;
    assign bus.cache_rd_ena_o = rd_ena;
    assign bus.cache_wr_ena_o = wr_ena;
    assign bus.cline_index_o  = cline_index;

endmodule

// File: tb/tb_sargantana_icache_access_sched.sv
// Directed bench for the I-cache access scheduler (IDX=6, 64-line flush walk).
module tb_sargantana_icache_access_sched;

    localparam int unsigned IDX = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    sargantana_icache_access_sched_if #(.IDX_W(IDX)) bus ();

    sargantana_icache_access_sched #(
        .ICACHE_N_WAY(4),
        .ICACHE_IDX_WIDTH(IDX)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    // {busy, ack, inval_ack, refill_gnt, rd_gnt, flush_ena, inval, rd_ena, wr_ena, idx}
    logic [14:0] obs;
    assign obs = {bus.flush_busy_o, bus.flush_ack_o, bus.inval_ack_o, bus.refill_gnt_o,
                  bus.rd_gnt_o, bus.flush_ena_o, bus.inval_o, bus.cache_rd_ena_o,
                  bus.cache_wr_ena_o, bus.cline_index_o};

    function automatic logic [14:0] ev(bit busy, bit ack, bit iack, bit rg, bit rdg,
                                       bit fe, bit inv, bit rde, bit wre, int idx);
        logic [5:0] i6;
        i6 = idx[5:0];
        return {busy, ack, iack, rg, rdg, fe, inv, rde, wre, i6};
    endfunction

    // Expected outputs p cycles after entering FLUSH_START (p = 0..65).
    function automatic logic [14:0] flush_exp(int p, bit iack);
        if (p == 0)       return ev(1, 0, iack, 0, 0, 1, 0, 0, 0, 0);
        else if (p <= 64) return ev(1, 0, iack, 0, 0, 0, 1, 0, 0, p - 1);
        else              return ev(1, 1, iack, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic clr_in();
        bus.flush_req_i  = 1'b0;
        bus.inval_req_i  = 1'b0;
        bus.inval_idx_i  = '0;
        bus.refill_req_i = 1'b0;
        bus.refill_idx_i = '0;
        bus.rd_req_i     = 1'b0;
        bus.rd_idx_i     = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e;
        clr_in();
        rst = 1'b1;
        bus.rd_req_i = 1'b1;
        bus.rd_idx_i = 6'd5;
        bus.flush_req_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs !== 15'd0) begin
                $display("FAIL reset_outputs c=%0d got=%h exp=%h", c, obs, 15'd0);
                err_cnt++;
            end
            next_cycle();
        end
        rst = 1'b0;
`ifdef ICACHE_FLUSH_ON_RESET_EN
        for (int c = 0; c <= 66; c++) begin
            e = (c <= 65) ? flush_exp(c, 0) : ev(0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL reset_flush c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            next_cycle();
        end
`else
        e = ev(0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
        @(negedge clk);
        vec_cnt++;
        if (obs !== e) begin
            $display("FAIL first_read got=%h exp=%h", obs, e);
            err_cnt++;
        end
        next_cycle();
`endif
        clr_in();
    endtask

    task automatic test_priority();
        logic [14:0] e;
        clr_in();
        bus.inval_req_i = 1'b1;
        bus.inval_idx_i = 6'd3;
        @(negedge clk);
        vec_cnt++;
        e = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (obs !== e) begin
            $display("FAIL prio_load got=%h exp=%h", obs, e);
            err_cnt++;
        end
        next_cycle();
        clr_in();
        bus.refill_req_i = 1'b1;
        bus.refill_idx_i = 6'd9;
        bus.rd_req_i     = 1'b1;
        bus.rd_idx_i     = 6'd5;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       e = ev(0, 0, 0, 1, 0, 0, 0, 0, 1, 9);
                1:       e = ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
                default: e = ev(0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
            endcase
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL prio c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            next_cycle();
            bus.refill_req_i = 1'b0;
        end
        clr_in();
    endtask

    task automatic test_inval_stall();
        logic [14:0] e;
        clr_in();
        for (int c = 0; c < 5; c++) begin
            bus.inval_req_i  = (c <= 2);
            bus.inval_idx_i  = (c == 0) ? 6'd8 : 6'd4;
            bus.refill_req_i = (c == 1);
            bus.refill_idx_i = 6'd9;
            case (c)
                0:       e = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
                1:       e = ev(0, 0, 0, 1, 0, 0, 0, 0, 1, 9);
                2:       e = ev(0, 0, 1, 0, 0, 0, 1, 0, 0, 8);
                3:       e = ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
                default: e = 15'd0;
            endcase
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL inval_stall c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            next_cycle();
        end
        clr_in();
    endtask

    task automatic test_flush();
        logic [14:0] e;
        int busy_cnt = 0;
        clr_in();
        bus.rd_req_i = 1'b1;
        bus.rd_idx_i = 6'd5;
        for (int c = 0; c <= 67; c++) begin
            bus.flush_req_i = (c == 0);
            if (c == 0)       e = 15'd0;
            else if (c <= 66) e = flush_exp(c - 1, 0);
            else              e = ev(0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL flush c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            if (bus.flush_busy_o === 1'b1) busy_cnt++;
            next_cycle();
        end
        vec_cnt++;
        if (busy_cnt !== 66) begin
            $display("FAIL flush_busy_len got=%0d exp=66", busy_cnt);
            err_cnt++;
        end
        clr_in();
    endtask

    task automatic test_reflush();
        logic [14:0] e;
        int ack_cnt = 0;
        clr_in();
        bus.rd_req_i = 1'b1;
        bus.rd_idx_i = 6'd5;
        for (int c = 0; c <= 133; c++) begin
            bus.flush_req_i = (c == 0) || (c == 22);
            if (c == 0)        e = 15'd0;
            else if (c <= 66)  e = flush_exp(c - 1, 0);
            else if (c <= 132) e = flush_exp(c - 67, 0);
            else               e = ev(0, 0, 0, 0, 1, 0, 0, 1, 0, 5);
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL reflush c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            if (bus.flush_ack_o === 1'b1) ack_cnt++;
            next_cycle();
        end
        vec_cnt++;
        if (ack_cnt !== 2) begin
            $display("FAIL reflush_acks got=%0d exp=2", ack_cnt);
            err_cnt++;
        end
        clr_in();
    endtask

    task automatic test_inval_during_flush();
        logic [14:0] e;
        clr_in();
        for (int c = 0; c <= 68; c++) begin
            bus.flush_req_i = (c == 0);
            bus.inval_req_i = (c == 12);
            bus.inval_idx_i = 6'd7;
            if (c == 0)       e = 15'd0;
            else if (c <= 66) e = flush_exp(c - 1, c == 12);
            else              e = 15'd0;
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL inval_flush c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            next_cycle();
        end
        clr_in();
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        clr_in();
        for (int c = 0; c < 5; c++) begin
            bus.inval_req_i = (c < 3);
            bus.inval_idx_i = 6'(c + 1);
            case (c)
                0:       e = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
                1:       e = ev(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
                2:       e = ev(0, 0, 1, 0, 0, 0, 1, 0, 0, 2);
                3:       e = ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
                default: e = 15'd0;
            endcase
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            next_cycle();
        end
        clr_in();
    endtask

    task automatic test_reset_mid_walk();
        logic [14:0] e;
        int ack_cnt = 0;
        clr_in();
        for (int c = 0; c <= 36; c++) begin
            bus.flush_req_i = (c == 0);
            rst = (c == 33);
            if (c == 0)       e = 15'd0;
            else if (c <= 32) e = flush_exp(c - 1, 0);
            else if (c == 33) e = 15'd0;
`ifdef ICACHE_FLUSH_ON_RESET_EN
            else              e = flush_exp(c - 34, 0);
`else
            else              e = 15'd0;
`endif
            @(negedge clk);
            vec_cnt++;
            if (obs !== e) begin
                $display("FAIL reset_mid_walk c=%0d got=%h exp=%h", c, obs, e);
                err_cnt++;
            end
            if (bus.flush_ack_o === 1'b1) ack_cnt++;
            next_cycle();
        end
        rst = 1'b0;
        vec_cnt++;
        if (ack_cnt !== 0) begin
            $display("FAIL reset_mid_walk_ack got=%0d exp=0", ack_cnt);
            err_cnt++;
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        test_reset();
        test_priority();
        test_inval_stall();
        test_flush();
        test_reflush();
        test_inval_during_flush();
        test_back_to_back();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
